alu_mc: RTL and testbench

- Parametrised multicycle ALU for the multicycle CPU datapath; next generation of the combinational ALU.
- Registered result and flags, start/done handshake.
- Single-cycle logic/arith/shift/compare ops, plus iterative multiply and unsigned divide/remainder executed over WIDTH cycles.
- Keeps the existing 6-bit opcode encoding so the control unit's current codes remain valid.

---
 rtl/alu_mc.sv | 222 ++++++++++++++++++++++
 tb/tb_alu_mc.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_mc.sv
// Multicycle ALU: single-cycle logic/arith/shift/compare ops plus iterative
// shift-add multiply and restoring unsigned divide/remainder, with a
// start/done handshake and registered result and flags.
module alu_mc #(
    parameter int unsigned WIDTH  = 32,
    parameter bit          MDU_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [5:0]       alu_op,
    input  logic [WIDTH-1:0] alu_a,
    input  logic [WIDTH-1:0] alu_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] alu_out,
    output logic             zero,
    output logic             carry,
    output logic             overflow
);
    localparam int unsigned MSB  = WIDTH - 1;
    localparam int unsigned WP   = WIDTH + 1;
    localparam int unsigned SHW  = $clog2(WIDTH);
    localparam int unsigned CNTW = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    localparam logic [5:0] OP_NOP  = 6'h00;
    localparam logic [5:0] OP_ADD  = 6'h20;
    localparam logic [5:0] OP_SUB  = 6'h02;
    localparam logic [5:0] OP_AND  = 6'h03;
    localparam logic [5:0] OP_OR   = 6'h04;
    localparam logic [5:0] OP_XOR  = 6'h05;
    localparam logic [5:0] OP_NOR  = 6'h06;
    localparam logic [5:0] OP_SLT  = 6'h07;
    localparam logic [5:0] OP_SLTU = 6'h08;
    localparam logic [5:0] OP_SLL  = 6'h09;
    localparam logic [5:0] OP_SRL  = 6'h0A;
    localparam logic [5:0] OP_SRA  = 6'h0B;
    localparam logic [5:0] OP_DEC  = 6'h3F;
    localparam logic [5:0] OP_MUL  = 6'h10;
    localparam logic [5:0] OP_DIVU = 6'h11;
    localparam logic [5:0] OP_REMU = 6'h12;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t            state_q;
    logic              busy_q;
    logic              done_q;
    logic [WIDTH-1:0]  out_q;
    logic              zero_q;
    logic              carry_q;
    logic              ovf_q;
    logic [CNTW-1:0]   cnt_q;
    logic              mul_q;      // latched op is MUL (else DIVU/REMU)
    logic              rem_q;      // latched op is REMU
    logic [WIDTH-1:0]  a_q;        // multiplicand (MUL) or divisor (DIV)
    logic [WIDTH-1:0]  b_q;        // multiplier (MUL) or dividend/quotient (DIV)
    logic [WIDTH-1:0]  acc_q;      // partial product (MUL) or remainder (DIV)

    logic [WIDTH:0]    sum_add;
    logic [WIDTH:0]    sum_sub;
    logic [WIDTH:0]    sum_dec;
    logic [SHW-1:0]    shamt;
    logic [WIDTH-1:0]  sc_res;
    logic              sc_c;
    logic              sc_v;
    logic              sc_iter;

    logic [WIDTH-1:0]  mul_acc_d;
    logic [WIDTH:0]    div_tmp;
    logic              div_ge;
    logic [WIDTH-1:0]  div_rem_d;
    logic [WIDTH-1:0]  div_quo_d;
    logic [WIDTH-1:0]  fin_res_d;

    // Single-cycle result, flags, and whether the op needs the iterative unit
    always_comb begin
        sum_add = {1'b0, alu_a} + {1'b0, alu_b};
        sum_sub = {1'b0, alu_a} + {1'b0, ~alu_b} + WP'(1);
        sum_dec = {1'b0, alu_a} + {1'b0, ~ONE} + WP'(1);
        shamt   = alu_b[SHW-1:0];
        sc_res  = '0;
        sc_c    = 1'b0;
        sc_v    = 1'b0;
        sc_iter = 1'b0;
        case (alu_op)
            OP_NOP: sc_res = '0;
            OP_ADD: begin
                sc_res = sum_add[WIDTH-1:0];
                sc_c   = sum_add[WIDTH];
                sc_v   = (alu_a[MSB] == alu_b[MSB]) && (sum_add[MSB] != alu_a[MSB]);
            end
            OP_SUB: begin
                sc_res = sum_sub[WIDTH-1:0];
                sc_c   = sum_sub[WIDTH];
                sc_v   = (alu_a[MSB] != alu_b[MSB]) && (sum_sub[MSB] != alu_a[MSB]);
            end
            OP_DEC: begin
                sc_res = sum_dec[WIDTH-1:0];
                sc_c   = sum_dec[WIDTH];
                sc_v   = alu_a[MSB] && !sum_dec[MSB];
            end
            OP_AND:  sc_res = alu_a & alu_b;
            OP_OR:   sc_res = alu_a | alu_b;
            OP_XOR:  sc_res = alu_a ^ alu_b;
            OP_NOR:  sc_res = ~(alu_a | alu_b);
            OP_SLT:  sc_res = WIDTH'($signed(alu_a) < $signed(alu_b));
            OP_SLTU: sc_res = WIDTH'(alu_a < alu_b);
            OP_SLL:  sc_res = alu_a << shamt;
            OP_SRL:  sc_res = alu_a >> shamt;
            OP_SRA:  sc_res = $signed(alu_a) >>> shamt;
            OP_MUL: begin
                if (MDU_EN) sc_iter = 1'b1;
            end
            OP_DIVU: begin
                if (MDU_EN) begin
                    if (alu_b == '0) sc_res  = '1;
                    else             sc_iter = 1'b1;
                end
            end
            OP_REMU: begin
                if (MDU_EN) begin
                    if (alu_b == '0) sc_res  = alu_a;
                    else             sc_iter = 1'b1;
                end
            end
            default: sc_res = '0;
        endcase
    end

    // One shift-add or restoring shift-subtract step on the latched operands
    always_comb begin
        mul_acc_d = acc_q + (b_q[0] ? a_q : '0);
        div_tmp   = {acc_q, b_q[MSB]};
        div_ge    = div_tmp >= {1'b0, a_q};
        div_rem_d = div_ge ? (div_tmp[WIDTH-1:0] - a_q) : div_tmp[WIDTH-1:0];
        div_quo_d = {b_q[WIDTH-2:0], div_ge};
        if (mul_q)      fin_res_d = mul_acc_d;
        else if (rem_q) fin_res_d = div_rem_d;
        else            fin_res_d = div_quo_d;
    end

    // Control FSM, iteration datapath and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            out_q   <= '0;
            zero_q  <= 1'b1;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
            mul_q   <= 1'b0;
            rem_q   <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE, S_FIN: begin
                    state_q <= S_IDLE;
                    if (start) begin
                        if (sc_iter) begin
                            state_q <= S_RUN;
                            busy_q  <= 1'b1;
                            cnt_q   <= CNTW'(WIDTH);
                            mul_q   <= (alu_op == OP_MUL);
                            rem_q   <= (alu_op == OP_REMU);
                            a_q     <= (alu_op == OP_MUL) ? alu_a : alu_b;
                            b_q     <= (alu_op == OP_MUL) ? alu_b : alu_a;
                            acc_q   <= '0;
                        end else begin
                            done_q  <= 1'b1;
                            out_q   <= sc_res;
                            zero_q  <= (sc_res == '0);
                            carry_q <= sc_c;
                            ovf_q   <= sc_v;
                        end
                    end
                end
                S_RUN: begin
                    cnt_q <= cnt_q - CNTW'(1);
                    if (mul_q) begin
                        a_q   <= a_q << 1;
                        b_q   <= b_q >> 1;
                        acc_q <= mul_acc_d;
                    end else begin
                        acc_q <= div_rem_d;
                        b_q   <= div_quo_d;
                    end
                    if (cnt_q == CNTW'(1)) begin
                        state_q <= S_FIN;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        out_q   <= fin_res_d;
                        zero_q  <= (fin_res_d == '0);
                        carry_q <= 1'b0;
                        ovf_q   <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign alu_out  = out_q;
    assign zero     = zero_q;
    assign carry    = carry_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_alu_mc.sv
// Bench for alu_mc: random and directed ops through a scoreboard, with an
// arithmetic reference model; a second instance covers the MDU_EN=0 build.
module tb_alu_mc;

    typedef struct {
        logic [31:0] res;
        logic        z;
        logic        c;
        logic        v;
        int          lat;
        int          due;
    } exp_t;

    logic        clk, rst, start, start0;
    logic [5:0]  alu_op;
    logic [31:0] alu_a, alu_b;
    logic        busy, done, zero, carry, overflow;
    logic [31:0] alu_out;
    logic        busy0, done0, zero0, carry0, overflow0;
    logic [31:0] alu_out0;

    exp_t        sbq[2][$];
    logic [31:0] hold[2];
    int          cyc = 0;
    int          busy_lo = 1;
    int          busy_hi = 0;
    int          n_vec = 0;
    int          n_cmp = 0;
    int          n_fail = 0;

    logic [5:0]  op_tab[16] = '{6'h00, 6'h20, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h07,
                                6'h08, 6'h09, 6'h0A, 6'h0B, 6'h3F, 6'h10, 6'h11, 6'h12};

    alu_mc #(.WIDTH(32), .MDU_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .start(start), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
        .busy(busy), .done(done), .alu_out(alu_out), .zero(zero), .carry(carry), .overflow(overflow)
    );

    alu_mc #(.WIDTH(32), .MDU_EN(1'b0)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
        .busy(busy0), .done(done0), .alu_out(alu_out0), .zero(zero0), .carry(carry0),
        .overflow(overflow0)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model from the opcode table using wide arithmetic
    function automatic exp_t model(input logic [5:0] op, input logic [31:0] a,
                                   input logic [31:0] b, input bit mden);
        exp_t        e;
        longint      sa, sb, sr;
        logic [63:0] t;
        int          sh;
        sa = $signed(a);
        sb = $signed(b);
        sh = int'(b % 32);
        sr = 0;
        e.res = 32'h0; e.c = 1'b0; e.v = 1'b0; e.lat = 1; e.due = 0;
        case (op)
            6'h20: begin
                e.res = a + b;
                t = {32'h0, a} + {32'h0, b};
                e.c = t[32];
                sr = sa + sb;
                e.v = (sr != longint'($signed(e.res)));
            end
            6'h02: begin
                e.res = a - b;
                e.c = (a >= b);
                sr = sa - sb;
                e.v = (sr != longint'($signed(e.res)));
            end
            6'h3F: begin
                e.res = a - 32'd1;
                e.c = (a >= 32'd1);
                sr = sa - 1;
                e.v = (sr != longint'($signed(e.res)));
            end
            6'h03: e.res = a & b;
            6'h04: e.res = a | b;
            6'h05: e.res = a ^ b;
            6'h06: e.res = ~(a | b);
            6'h07: e.res = (sa < sb) ? 32'd1 : 32'd0;
            6'h08: e.res = (a < b) ? 32'd1 : 32'd0;
            6'h09: e.res = a << sh;
            6'h0A: e.res = a >> sh;
            6'h0B: e.res = 32'(sa >>> sh);
            6'h10: if (mden) begin
                t = {32'h0, a} * {32'h0, b};
                e.res = t[31:0];
                e.lat = 33;
            end
            6'h11: if (mden) begin
                if (b == 0) e.res = 32'hFFFF_FFFF;
                else begin e.res = a / b; e.lat = 33; end
            end
            6'h12: if (mden) begin
                if (b == 0) e.res = a;
                else begin e.res = a % b; e.lat = 33; end
            end
            default: e.res = 32'h0;
        endcase
        e.z = (e.res == 32'h0);
        return e;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            5: return 32'($urandom_range(0, 40));
            default: return $urandom;
        endcase
    endfunction

    // Scoreboard check of one instance's done/hold behaviour for this cycle
    task automatic sb_check(input int s, input logic d, input logic [31:0] o,
                            input logic z, input logic c, input logic v);
        exp_t e;
        if (d === 1'b1) begin
            n_cmp++;
            if (sbq[s].size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_done dut%0d cyc=%0d got out=%h, want no done", s, cyc, o);
            end else begin
                e = sbq[s].pop_front();
                if (o !== e.res || z !== e.z || c !== e.c || v !== e.v || cyc != e.due) begin
                    n_fail++;
                    $display("FAIL result dut%0d got out=%h z=%b c=%b v=%b cyc=%0d, want out=%h z=%b c=%b v=%b cyc=%0d",
                             s, o, z, c, v, cyc, e.res, e.z, e.c, e.v, e.due);
                end
                hold[s] = e.res;
            end
        end else begin
            n_cmp++;
            if (o !== hold[s]) begin
                n_fail++;
                $display("FAIL hold dut%0d cyc=%0d got out=%h, want %h", s, cyc, o, hold[s]);
            end
            if (sbq[s].size() > 0 && sbq[s][0].due < cyc) begin
                n_cmp++;
                n_fail++;
                $display("FAIL no_done dut%0d cyc=%0d got no done, want done at %0d",
                         s, cyc, sbq[s][0].due);
                void'(sbq[s].pop_front());
            end
        end
    endtask

    // Monitor: sample #1 after each rising edge
    always @(posedge clk) begin
        logic rst_s;
        rst_s = rst;
        cyc = cyc + 1;
        #1;
        if (rst_s) begin
            n_cmp++;
            if (busy !== 1'b0 || done !== 1'b0 || alu_out !== 32'h0 || zero !== 1'b1 ||
                carry !== 1'b0 || overflow !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_state dut1 got busy=%b done=%b out=%h z=%b c=%b v=%b, want 0 0 00000000 1 0 0",
                         busy, done, alu_out, zero, carry, overflow);
            end
            n_cmp++;
            if (busy0 !== 1'b0 || done0 !== 1'b0 || alu_out0 !== 32'h0 || zero0 !== 1'b1 ||
                carry0 !== 1'b0 || overflow0 !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_state dut0 got busy=%b done=%b out=%h z=%b, want 0 0 00000000 1",
                         busy0, done0, alu_out0, zero0);
            end
            hold[0] = 32'h0;
            hold[1] = 32'h0;
        end else begin
            n_cmp++;
            if (busy !== (cyc >= busy_lo && cyc <= busy_hi)) begin
                n_fail++;
                $display("FAIL busy dut1 cyc=%0d got %b, want %b", cyc, busy,
                         (cyc >= busy_lo && cyc <= busy_hi));
            end
            n_cmp++;
            if (busy0 !== 1'b0) begin
                n_fail++;
                $display("FAIL busy dut0 cyc=%0d got %b, want 0", cyc, busy0);
            end
            sb_check(1, done, alu_out, zero, carry, overflow);
            sb_check(0, done0, alu_out0, zero0, carry0, overflow0);
        end
    end

    task automatic rand_inputs();
        alu_op = 6'($urandom);
        alu_a  = $urandom;
        alu_b  = $urandom;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            rst = 1'b0; start = 1'b0; start0 = 1'b0;
            rand_inputs();
        end
    endtask

    // Wait until the DUT accepts; random start pulses while busy must be ignored
    task automatic wait_ready();
        while (cyc + 1 <= busy_hi) begin
            @(negedge clk);
            rst = 1'b0; start0 = 1'b0;
            rand_inputs();
            start = ($urandom_range(0, 2) == 0);
        end
    endtask

    task automatic issue(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        wait_ready();
        @(negedge clk);
        rst = 1'b0; start0 = 1'b0; start = 1'b1;
        alu_op = op; alu_a = a; alu_b = b;
        e = model(op, a, b, 1'b1);
        e.due = cyc + e.lat;
        if (e.lat > 1) begin
            busy_lo = cyc + 1;
            busy_hi = cyc + 32;
        end
        sbq[1].push_back(e);
        n_vec++;
    endtask

    task automatic issue0(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        @(negedge clk);
        rst = 1'b0; start = 1'b0; start0 = 1'b1;
        alu_op = op; alu_a = a; alu_b = b;
        e = model(op, a, b, 1'b0);
        e.due = cyc + e.lat;
        sbq[0].push_back(e);
        n_vec++;
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        rst = 1'b1; start = 1'b0; start0 = 1'b0;
        sbq[0].delete();
        sbq[1].delete();
        if (busy_hi > cyc) busy_hi = cyc;
        repeat (n - 1) @(negedge clk);
    endtask

    initial begin
        logic [5:0]  op;
        logic [31:0] a, b;
        rst = 1'b1; start = 1'b0; start0 = 1'b0;
        alu_op = 6'h0; alu_a = 32'h0; alu_b = 32'h0;
        hold[0] = 32'h0; hold[1] = 32'h0;
        @(negedge clk);

        // back-to-back single-cycle ops
        issue(6'h20, 32'h7FFF_FFFF, 32'h1);
        issue(6'h02, 32'd5, 32'd7);
        issue(6'h06, 32'h0, 32'h0);
        // shifts and compares
        issue(6'h0B, 32'h8000_0000, 32'd4);
        issue(6'h0A, 32'h8000_0000, 32'd4);
        issue(6'h09, 32'h1, 32'h25);
        issue(6'h07, 32'hFFFF_FFFF, 32'h1);
        issue(6'h08, 32'hFFFF_FFFF, 32'h1);
        issue(6'h3F, 32'h8000_0000, 32'h0);
        issue(6'h3F, 32'h0, 32'h0);
        // iterative ops; follow-on start lands in the done cycle
        issue(6'h10, 32'h1234_5678, 32'h10);
        issue(6'h11, 32'd100, 32'd7);
        issue(6'h12, 32'd100, 32'd7);
        issue(6'h11, 32'd5, 32'd0);
        issue(6'h12, 32'd5, 32'd0);
        idle(2);
        // reset in the middle of a multiply
        issue(6'h10, 32'h1234_5678, 32'h10);
        idle(9);
        do_reset(1);
        issue(6'h20, 32'd2, 32'd3);
        idle(2);

        for (int i = 0; i < 200; i++) begin
            op = op_tab[$urandom_range(0, 15)];
            if ($urandom_range(0, 9) == 0) op = 6'($urandom);
            a = pick();
            b = pick();
            issue(op, a, b);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        wait_ready();
        idle(3);

        // MDU_EN=0 instance
        issue0(6'h10, 32'd3, 32'd3);
        issue0(6'h15, $urandom, $urandom);
        issue0(6'h11, 32'd100, 32'd7);
        issue0(6'h12, 32'd100, 32'd0);
        issue0(6'h20, 32'hFFFF_FFFF, 32'h1);
        for (int i = 0; i < 30; i++) begin
            issue0(op_tab[$urandom_range(0, 15)], pick(), pick());
        end
        idle(40);

        n_cmp++;
        if (sbq[0].size() != 0 || sbq[1].size() != 0) begin
            n_fail++;
            $display("FAIL drain got %0d/%0d pending, want 0/0", sbq[0].size(), sbq[1].size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
